// File: rtl/fir_interp_if.sv
// FIFO-facing handshake bundle for the interpolating FIR: upstream pop side and downstream push side.
interface fir_interp_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_rd_en;
  logic                  x_empty;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_out_full;
  logic                  y_wr_en;

  // master: the filter; slave: the surrounding FIFOs
  modport master (
    input  x_in, x_empty, y_out_full,
    output x_rd_en, y_out, y_wr_en
  );

  modport slave (
    output x_in, x_empty, y_out_full,
    input  x_rd_en, y_out, y_wr_en
  );
endinterface

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: each popped sample yields INTERPOLATION outputs, one MAC per cycle,
// products dequantized by QBITS before a wrapping DATA_WIDTH accumulation.
module fir_interp #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAPS          = 32,
  parameter int INTERPOLATION = 4,
  parameter int QBITS         = 10,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF = {
    -32'sd3,   -32'sd8,   -32'sd11,  -32'sd5,   32'sd12,   32'sd38,   32'sd60,   32'sd62,
    32'sd28,   -32'sd40,  -32'sd118, -32'sd165, -32'sd136, 32'sd0,    32'sd236,  32'sd520,
    32'sd520,  32'sd236,  32'sd0,    -32'sd136, -32'sd165, -32'sd118, -32'sd40,  32'sd28,
    32'sd62,   32'sd60,   32'sd38,   32'sd12,   -32'sd5,   -32'sd11,  -32'sd8,   -32'sd3
  }
) (
  input  logic         clock,
  input  logic         reset,
  fir_interp_if.master bus
);

  localparam int N  = TAPS / INTERPOLATION;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    S_READ,
    S_MAC,
    S_WRITE
  } state_t;

  state_t                       state, next_state;
  logic signed [DATA_WIDTH-1:0] hist [N];
  logic        [DATA_WIDTH-1:0] acc;
  logic        [PW-1:0]         p;
  logic        [JW-1:0]         j;

  logic        [TW-1:0]           tap_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic        [DATA_WIDTH-1:0]   term;
  logic                           last_tap, last_phase;

  // Phase p of the polyphase decomposition uses taps p, p+L, p+2L, ... against x[0], x[1], ...
  assign tap_idx    = TW'(int'(j) * INTERPOLATION + int'(p));
  assign prod       = $signed(COEFF[tap_idx]) * hist[j];
  assign term       = DATA_WIDTH'(prod >>> QBITS);
  assign last_tap   = (j == JW'(N - 1));
  assign last_phase = (p == PW'(INTERPOLATION - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= S_READ;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    next_state  = state;
    bus.x_rd_en = 1'b0;
    bus.y_wr_en = 1'b0;
    bus.y_out   = '0;
    case (state)
      S_READ: begin
        bus.x_rd_en = !bus.x_empty;
        if (!bus.x_empty) next_state = S_MAC;
      end
      S_MAC: begin
        if (last_tap) next_state = S_WRITE;
      end
      S_WRITE: begin
        bus.y_out   = acc;
        bus.y_wr_en = !bus.y_out_full;
        if (!bus.y_out_full) next_state = last_phase ? S_READ : S_MAC;
      end
      default: next_state = S_READ;
    endcase
    // Reset silences the handshakes in the very cycle it is asserted, so no pop is lost
    // and no half-finished output escapes.
    if (reset) begin
      next_state  = S_READ;
      bus.x_rd_en = 1'b0;
      bus.y_wr_en = 1'b0;
      bus.y_out   = '0;
    end
  end

  // NOTE: the history is a small register file that must come up cleared, so it sits on reset
  // with the rest of the datapath rather than being left as an uninitialised memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      acc <= '0;
      p   <= '0;
      j   <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (bus.x_rd_en) begin
            hist[0] <= bus.x_in;
            for (int i = 1; i < N; i++) hist[i] <= hist[i-1];
            acc <= '0;
            j   <= '0;
            p   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + term;
          j   <= last_tap ? '0 : j + JW'(1);
        end
        S_WRITE: begin
          if (bus.y_wr_en && !last_phase) begin
            p   <= p + PW'(1);
            acc <= '0;
            j   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Self-checking bench: two filter instances (ramp and flat coefficient tables) share one input
// stream; a behavioural polyphase model predicts every output word.
module tb_fir_interp;

  localparam int DW    = 32;
  localparam int TAPS  = 32;
  localparam int L     = 4;
  localparam int N     = TAPS / L;
  localparam int QBITS = 10;

  function automatic logic [0:TAPS-1][DW-1:0] make_coeffs(bit ramp);
    logic [0:TAPS-1][DW-1:0] c;
    for (int k = 0; k < TAPS; k++) c[k] = ramp ? DW'((k + 1) * 1024) : DW'(512);
    return c;
  endfunction

  localparam logic [0:TAPS-1][DW-1:0] COEFF_A = make_coeffs(1'b1);
  localparam logic [0:TAPS-1][DW-1:0] COEFF_B = make_coeffs(1'b0);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fir_interp_if #(.DATA_WIDTH(DW)) ifa ();
  fir_interp_if #(.DATA_WIDTH(DW)) ifb ();

  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERPOLATION(L), .QBITS(QBITS), .COEFF(COEFF_A))
    u_a (.clock(clock), .reset(reset), .bus(ifa.master));
  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERPOLATION(L), .QBITS(QBITS), .COEFF(COEFF_B))
    u_b (.clock(clock), .reset(reset), .bus(ifb.master));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d) at %0t",
               name, act, $signed(act), exp, $signed(exp), $time);
    end
  endtask

  task automatic flag(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] hist_m [N];
  logic [DW-1:0] in_q  [$];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] got_a [$];
  logic [DW-1:0] got_b [$];
  int            pop_cyc [$];
  int            wr_cyc  [$];
  int            cyc = 0;

  function automatic logic [DW-1:0] model_out(bit use_b, int p);
    logic [DW-1:0] sum = '0;
    for (int j = 0; j < N; j++) begin
      int     c    = use_b ? int'(COEFF_B[j*L + p]) : int'(COEFF_A[j*L + p]);
      longint prod = longint'(c) * longint'(int'(hist_m[j]));
      sum += DW'(prod >>> QBITS);
    end
    return sum;
  endfunction

  task automatic push_sample(logic [DW-1:0] v);
    in_q.push_back(v);
    for (int i = N - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = v;
    for (int p = 0; p < L; p++) begin
      exp_a.push_back(model_out(1'b0, p));
      exp_b.push_back(model_out(1'b1, p));
    end
  endtask

  // ---------------- FIFO emulation and monitor ----------------
  bit   stall_empty = 1'b0;
  bit   hold_full   = 1'b0;
  bit   rand_mode   = 1'b0;
  logic rd_seen     = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    rd_seen = ifa.x_rd_en;
    check("rd_lockstep", DW'(ifb.x_rd_en), DW'(ifa.x_rd_en));
    check("rd_wr_exclusive", DW'(ifa.x_rd_en & ifa.y_wr_en), '0);
    if (ifa.x_rd_en) pop_cyc.push_back(cyc);
    if (ifa.y_wr_en) begin
      wr_cyc.push_back(cyc);
      got_a.push_back(ifa.y_out);
      if (exp_a.size() == 0) flag("a_unexpected_write");
      else check("a_out", ifa.y_out, exp_a.pop_front());
    end
    if (ifb.y_wr_en) begin
      got_b.push_back(ifb.y_out);
      if (exp_b.size() == 0) flag("b_unexpected_write");
      else check("b_out", ifb.y_out, exp_b.pop_front());
    end
  end

  always @(posedge clock) begin
    logic e, f;
    #1;
    if (rd_seen && in_q.size() > 0) void'(in_q.pop_front());
    e = stall_empty || (in_q.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
    f = hold_full || (rand_mode && $urandom_range(0, 3) == 0);
    ifa.x_in       = (in_q.size() > 0) ? in_q[0] : '0;
    ifb.x_in       = (in_q.size() > 0) ? in_q[0] : '0;
    ifa.x_empty    = e;
    ifb.x_empty    = e;
    ifa.y_out_full = f;
    ifb.y_out_full = f;
  end

  // ---------------- helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    in_q.delete();  exp_a.delete(); exp_b.delete();
    got_a.delete(); got_b.delete(); pop_cyc.delete(); wr_cyc.delete();
    for (int i = 0; i < N; i++) hist_m[i] = '0;
    stall_empty = 1'b0;
    hold_full   = 1'b0;
    rand_mode   = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic wait_writes(int n, int budget, string name);
    int k = 0;
    while (got_a.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_a.size() < n) flag(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random scenarios ----------------
  initial begin
    do_reset(3);
    check("reset_rd_en", DW'(ifa.x_rd_en), '0);
    check("reset_wr_en", DW'(ifa.y_wr_en), '0);
    check("reset_y_out", ifa.y_out, '0);

    // Impulse through the ramp table reads the taps back in order.
    push_sample(32'd1);
    repeat (8) push_sample(32'd0);
    wait_writes(36, 800, "impulse_timeout");
    foreach (got_a[i]) if (i < 32 && (i % 5 == 0 || i == 31))
      check($sformatf("impulse_%0d", i), got_a[i], DW'(i + 1));
    check("impulse_tail", got_a[35], 32'd0);
    check("impulse_b_flat", got_b[0], 32'd0);
    check("first_write_latency", DW'(wr_cyc[0] - pop_cyc[0]), DW'(N + 1));
    check("write_spacing", DW'(wr_cyc[1] - wr_cyc[0]), DW'(N + 1));
    check("pop_spacing", DW'(pop_cyc[1] - pop_cyc[0]), DW'(L * (N + 1) + 1));
    tick(3);
    check("impulse_drained", DW'(exp_a.size()), '0);

    // DC fill: flat 512 table with input 2048 gives m*1024 per input.
    do_reset(2);
    repeat (10) push_sample(32'd2048);
    wait_writes(40, 1000, "dc_timeout");
    check("dc_b_in1", got_b[0], 32'd1024);
    check("dc_b_in2", got_b[4], 32'd2048);
    check("dc_b_in4", got_b[13], 32'd4096);
    check("dc_b_in8", got_b[28], 32'd8192);
    check("dc_b_in10", got_b[39], 32'd8192);
    check("dc_a_first", got_a[0], 32'd2048);
    check("dc_a_full_p0", got_a[28], 32'd245760);
    check("dc_a_full_p3", got_a[31], 32'd294912);

    // Negative input: arithmetic shift must keep the sign.
    do_reset(2);
    push_sample(32'hFFFF_F800);
    wait_writes(4, 200, "neg_timeout");
    for (int p = 0; p < L; p++) check($sformatf("neg_b_p%0d", p), got_b[p], 32'hFFFF_FC00);
    check("neg_a_p0", got_a[0], 32'hFFFF_F800);
    check("neg_a_p3", got_a[3], 32'hFFFF_E000);

    // Backpressure: full held for five cycles of the first write slot.
    do_reset(2);
    hold_full = 1'b1;
    push_sample(32'd1);
    push_sample(32'd0);
    begin
      int k = 0;
      while (pop_cyc.size() == 0 && k < 50) begin tick(); k++; end
    end
    if (pop_cyc.size() == 0) flag("bp_no_pop");
    else begin
      while (cyc < pop_cyc[0] + N + 1) tick();
      for (int s = 0; s < 5; s++) begin
        check("bp_wr_en_low", DW'(ifa.y_wr_en), '0);
        check("bp_rd_en_low", DW'(ifa.x_rd_en), '0);
        check("bp_y_out_stable", ifa.y_out, 32'd1);
        if (s == 4) hold_full = 1'b0;
        tick();
      end
      check("bp_release_write", DW'(ifa.y_wr_en), 32'd1);
      check("bp_release_value", ifa.y_out, 32'd1);
    end
    wait_writes(8, 400, "bp_timeout");
    check("bp_seq_1", got_a[1], 32'd2);
    check("bp_hist_4", got_a[4], 32'd5);
    check("bp_hist_7", got_a[7], 32'd8);

    // Empty stall between inputs.
    do_reset(2);
    push_sample(32'd3);
    wait_writes(4, 200, "stall_first_timeout");
    tick(2);
    stall_empty = 1'b1;
    push_sample(32'd0);
    tick();
    for (int s = 0; s < 10; s++) begin
      check("stall_no_pop", DW'(ifa.x_rd_en), '0);
      check("stall_no_write", DW'(ifa.y_wr_en), '0);
      tick();
    end
    stall_empty = 1'b0;
    tick();
    check("stall_resume_pop", DW'(ifa.x_rd_en), 32'd1);
    wait_writes(8, 400, "stall_timeout");
    check("stall_out_0", got_a[0], 32'd3);
    check("stall_out_4", got_a[4], 32'd15);

    // Randomised samples with random empty/full handshakes.
    do_reset(2);
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_sample(DW'($urandom));
      tick($urandom_range(0, 20));
    end
    begin
      int k = 0;
      while ((exp_a.size() > 0 || exp_b.size() > 0) && k < 8000) begin tick(); k++; end
    end
    check("random_drained_a", DW'(exp_a.size()), '0);
    check("random_drained_b", DW'(exp_b.size()), '0);
    rand_mode = 1'b0;

    // Reset during phase 2 accumulation, then a clean impulse.
    do_reset(2);
    push_sample(32'd1);
    repeat (7) push_sample(32'd0);
    wait_writes(2, 200, "midrst_timeout");
    tick(2);
    do_reset(1);
    check("midrst_wr_en", DW'(ifa.y_wr_en), '0);
    check("midrst_y_out", ifa.y_out, '0);
    tick(20);
    check("midrst_no_stale_write", DW'(got_a.size()), '0);
    push_sample(32'd1);
    repeat (7) push_sample(32'd0);
    wait_writes(32, 800, "midrst_impulse_timeout");
    check("midrst_impulse_0", got_a[0], 32'd1);
    check("midrst_impulse_16", got_a[16], 32'd17);
    check("midrst_impulse_31", got_a[31], 32'd32);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_interp.md
Name: fir_interp

Overview:
- Polyphase interpolating FIR for the FM radio datapath.
- Upsamples by INTERPOLATION: each input sample popped from the upstream FIFO produces INTERPOLATION filtered output samples, written to the downstream FIFO.
- Counterpart of the decimating FIR stage. Uses the same FIFO read/write handshakes and the same fixed-point convention: each product is dequantized before accumulation.
- Time-multiplexed: one multiplier, one MAC per cycle.

Parameters:
- DATA_WIDTH, 32, sample and coefficient width; signed two's complement.
- TAPS, 32, total filter taps. Must be a multiple of INTERPOLATION.
- INTERPOLATION, 4, upsampling factor L.
- QBITS, 10, dequantization shift (fixed-point fraction bits).
- COEFF, [0:TAPS-1][DATA_WIDTH-1:0], default 32-tap lowpass table; COEFF[k] is tap k.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- x_in  in  DATA_WIDTH  input sample (upstream FIFO dout).
- x_rd_en  out  1  pop upstream FIFO.
- x_empty  in  1  upstream FIFO empty.
- y_out  out  DATA_WIDTH  output sample (downstream FIFO din).
- y_out_full  in  1  downstream FIFO full.
- y_wr_en  out  1  push downstream FIFO.

Behaviour:
- One clock domain; reset is synchronous and active-high. Port names are clock/reset as above.
- Let N = TAPS/INTERPOLATION (default 8).
- State: history x[0..N-1] (x[0] newest), accumulator acc, phase p (0..L-1), tap counter j (0..N-1), FSM state.
- Reset, sampled on a clock edge, does the following:
  - clears x, acc, p, j; state = S_READ.
  - forces x_rd_en = 0, y_wr_en = 0, y_out = 0.
  - abandons any in-progress MAC or write immediately; no partial output is emitted.
- S_READ:
  - x_rd_en = !x_empty, combinational, this state only.
  - On pop: x[0] <= x_in, x[i] <= x[i-1]; acc <= 0; j <= 0; p <= 0; go to S_MAC.
  - If empty: hold, no state change.
- S_MAC:
  - Each cycle: prod = signed COEFF[j*L + p] * signed x[j], 2*DATA_WIDTH-bit full product.
  - term = prod >>> QBITS (arithmetic), truncated to DATA_WIDTH.
  - acc <= acc + term, DATA_WIDTH-bit wrapping, no saturation.
  - j increments; after j == N-1, go to S_WRITE. Exactly N cycles.
- S_WRITE:
  - y_out = acc (registered value). y_wr_en = !y_out_full, combinational.
  - Outside S_WRITE, y_out = 0 and y_wr_en = 0.
  - If full: hold with acc stable and no reads.
  - On write:
    - if p == L-1, go to S_READ.
    - else p <= p+1, acc <= 0, j <= 0, go to S_MAC.
- x_rd_en and y_wr_en are never both high in the same cycle.
- Timing, with no stalls:
  - pop at cycle 0; first write at cycle N+1.
  - subsequent writes every N+1 cycles.
  - next pop possible the cycle after the L-th write.
  - throughput = L*(N+1)+1 cycles per input (37 by default).
- Output order per input: phase 0 first, up to phase L-1.
- No gain compensation for L is applied; the coefficient table absorbs it.
- History is not cleared between inputs, only by reset.

Test Plan:
- Impulse response:
  - COEFF[k] = (k+1)*1024; feed 1, then seven 0s.
  - Required output: 32 writes with values 1,2,3,...,32 in order, then zeros for further 0 inputs.
- DC fill:
  - All COEFF = 1024; feed constant 1024.
  - Outputs for the m-th input (m = 1..8) are m*1024, four writes each.
  - From the 8th input onward, every output is 8192.
- Negative/arithmetic shift:
  - COEFF = 512; x = -2048 single sample (history otherwise 0).
  - Each term = -1024; all 4 outputs = -1024, i.e. 0xFFFFFC00.
- Backpressure:
  - Hold y_out_full = 1 for 5 cycles on entering S_WRITE.
  - y_wr_en stays 0, y_out holds a stable value, x_rd_en stays 0.
  - One write occurs the cycle after full drops; the sequence is otherwise unchanged.
- Empty stall:
  - x_empty = 1 for 10 cycles between inputs.
  - No pops and no writes during the stall; resumes with a pop the cycle x_empty = 0.
- Mid-operation reset:
  - Assert reset for 1 cycle during S_MAC of phase 2.
  - Next cycle: y_wr_en = 0, y_out = 0.
  - Subsequent impulse test reproduces exactly 1..32, showing no stale history.
